// File: rtl/io_dev_arbiter_if.sv
// Handshake bundle between the I/O unit, the peripherals and the operator panel.
// The arbiter connects through the slave modport; its environment drives the master modport.
interface io_dev_arbiter_if;
  // Operator panel
  logic [1:0] src_en_from_pnl;
  logic [1:0] snk_en_from_pnl;
  logic       clear_error_from_pnl;
  logic       in_busy_to_pnl;
  logic       out_busy_to_pnl;
  logic [1:0] timeout_to_pnl;

  // I/O unit input side
  logic       input_rdy_to_unit;
  logic       input_ack_from_unit;
  logic [4:0] input_data_to_unit;

  // Input sources: photo tape reader (0) and panel keyboard (1)
  logic [1:0] src_rdy_from_dev;
  logic [1:0] src_ack_to_dev;
  logic [9:0] src_data_from_dev;

  // I/O unit output side
  logic       output_rdy_from_unit;
  logic       output_ack_to_unit;
  logic [4:0] output_data_from_unit;

  // Output sinks: printer (0) and tape punch (1)
  logic [1:0] snk_rdy_to_dev;
  logic [1:0] snk_ack_from_dev;
  logic [4:0] snk_data_to_dev;

  modport slave (
    input  src_en_from_pnl, snk_en_from_pnl, clear_error_from_pnl,
    input  input_ack_from_unit, src_rdy_from_dev, src_data_from_dev,
    input  output_rdy_from_unit, output_data_from_unit, snk_ack_from_dev,
    output input_rdy_to_unit, input_data_to_unit, src_ack_to_dev,
    output output_ack_to_unit, snk_rdy_to_dev, snk_data_to_dev,
    output in_busy_to_pnl, out_busy_to_pnl, timeout_to_pnl
  );

  modport master (
    output src_en_from_pnl, snk_en_from_pnl, clear_error_from_pnl,
    output input_ack_from_unit, src_rdy_from_dev, src_data_from_dev,
    output output_rdy_from_unit, output_data_from_unit, snk_ack_from_dev,
    input  input_rdy_to_unit, input_data_to_unit, src_ack_to_dev,
    input  output_ack_to_unit, snk_rdy_to_dev, snk_data_to_dev,
    input  in_busy_to_pnl, out_busy_to_pnl, timeout_to_pnl
  );
endinterface

// File: rtl/io_dev_arbiter.sv
// Shares the I/O unit's input channel between two sources and broadcasts output characters
// to the enabled sinks, with 4-phase handshakes on both sides and a per-character sink watchdog.
module io_dev_arbiter #(
  parameter bit          RR_INPUT       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 20'd1000000,
  parameter int unsigned TMR_W          = 20
) (
  input  logic             clk,
  input  logic             reset,
  io_dev_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IN_IDLE   = 3'b001,
    IN_FWD    = 3'b010,
    IN_DEVACK = 3'b100
  } in_state_t;

  typedef enum logic [2:0] {
    OUT_IDLE = 3'b001,
    OUT_SEND = 3'b010,
    OUT_ACK  = 3'b100
  } out_state_t;

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------- input side
  in_state_t  in_state;
  logic       grant_r;
  logic       rr_ptr;
  logic [4:0] data_in_r;
  logic       input_rdy_r;
  logic [1:0] src_ack_r;
  logic       in_busy_r;

  logic [1:0] req;
  logic       grant_pick;
  logic [4:0] src_word;

  assign req      = bus.src_rdy_from_dev & bus.src_en_from_pnl;
  assign src_word = grant_pick ? bus.src_data_from_dev[9:5] : bus.src_data_from_dev[4:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_pick = 1'b0;
    if (req == 2'b10)
      grant_pick = 1'b1;
    else if (req == 2'b11)
      grant_pick = RR_INPUT ? rr_ptr : 1'b0;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, since every output must read 0 right after reset.
    if (reset) begin
      in_state    <= IN_IDLE;
      grant_r     <= 1'b0;
      rr_ptr      <= 1'b0;
      data_in_r   <= '0;
      input_rdy_r <= 1'b0;
      src_ack_r   <= '0;
      in_busy_r   <= 1'b0;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (req != 2'b00) begin
            grant_r   <= grant_pick;
            data_in_r <= src_word;
            in_busy_r <= 1'b1;
            in_state  <= IN_FWD;
          end
        end
        IN_FWD: begin
          // rdy is raised one cycle after the grant is registered and dropped on the unit ack
          if (bus.input_ack_from_unit) begin
            input_rdy_r <= 1'b0;
            src_ack_r   <= grant_r ? 2'b10 : 2'b01;
            in_state    <= IN_DEVACK;
          end else begin
            input_rdy_r <= 1'b1;
          end
        end
        IN_DEVACK: begin
          if (!bus.src_rdy_from_dev[grant_r] && !bus.input_ack_from_unit) begin
            src_ack_r <= '0;
            in_busy_r <= 1'b0;
            rr_ptr    <= ~grant_r;
            in_state  <= IN_IDLE;
          end
        end
        default: begin
          input_rdy_r <= 1'b0;
          src_ack_r   <= '0;
          in_busy_r   <= 1'b0;
          in_state    <= IN_IDLE;
        end
      endcase
    end
  end

  assign bus.input_rdy_to_unit  = input_rdy_r;
  assign bus.input_data_to_unit = data_in_r;
  assign bus.src_ack_to_dev     = src_ack_r;
  assign bus.in_busy_to_pnl     = in_busy_r;

  // --------------------------------------------------------------- output side
  out_state_t       out_state;
  logic [4:0]       snk_data_r;
  logic [1:0]       mask_r;
  logic [1:0]       done_r;
  logic [1:0]       timed_out_r;
  logic [1:0]       tmo_flag_r;
  logic [1:0]       snk_rdy_r;
  logic             out_ack_r;
  logic             out_busy_r;
  logic [TMR_W-1:0] timer_r;

  logic       tmo_hit;
  logic [1:0] ack_live;
  logic [1:0] pending;
  logic [1:0] new_tmo;
  logic [1:0] done_next;
  logic       send_done;
  logic       ack_release;

  always_comb begin
    tmo_hit     = (out_state == OUT_SEND) && (timer_r == TMO_LAST);
    ack_live    = bus.snk_ack_from_dev & mask_r & ~done_r;
    // a sink acking in the watchdog's last cycle counts as answered, not timed out
    pending     = mask_r & ~done_r & ~bus.snk_ack_from_dev;
    new_tmo     = tmo_hit ? pending : 2'b00;
    done_next   = done_r | ack_live | new_tmo;
    send_done   = ((done_next & mask_r) == mask_r);
    ack_release = !bus.output_rdy_from_unit &&
                  ((bus.snk_ack_from_dev & mask_r & ~timed_out_r) == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_state   <= OUT_IDLE;
      snk_data_r  <= '0;
      mask_r      <= '0;
      done_r      <= '0;
      timed_out_r <= '0;
      tmo_flag_r  <= '0;
      snk_rdy_r   <= '0;
      out_ack_r   <= 1'b0;
      out_busy_r  <= 1'b0;
      timer_r     <= '0;
    end else begin
      // sticky panel flag: a fresh timeout beats a simultaneous clear
      tmo_flag_r <= (bus.clear_error_from_pnl ? 2'b00 : tmo_flag_r) | new_tmo;

      case (out_state)
        OUT_IDLE: begin
          if (bus.output_rdy_from_unit) begin
            snk_data_r  <= bus.output_data_from_unit;
            mask_r      <= bus.snk_en_from_pnl;
            done_r      <= '0;
            timed_out_r <= '0;
            timer_r     <= '0;
            snk_rdy_r   <= bus.snk_en_from_pnl;
            out_busy_r  <= 1'b1;
            out_state   <= OUT_SEND;
          end
        end
        OUT_SEND: begin
          timer_r     <= timer_r + 1'b1;
          done_r      <= done_next;
          timed_out_r <= timed_out_r | new_tmo;
          if (send_done) begin
            snk_rdy_r <= '0;
            out_ack_r <= 1'b1;
            out_state <= OUT_ACK;
          end else begin
            snk_rdy_r <= mask_r & ~done_next;
          end
        end
        OUT_ACK: begin
          if (ack_release) begin
            out_ack_r  <= 1'b0;
            out_busy_r <= 1'b0;
            out_state  <= OUT_IDLE;
          end
        end
        default: begin
          snk_rdy_r  <= '0;
          out_ack_r  <= 1'b0;
          out_busy_r <= 1'b0;
          out_state  <= OUT_IDLE;
        end
      endcase
    end
  end

  assign bus.snk_rdy_to_dev     = snk_rdy_r;
  assign bus.snk_data_to_dev    = snk_data_r;
  assign bus.output_ack_to_unit = out_ack_r;
  assign bus.out_busy_to_pnl    = out_busy_r;
  assign bus.timeout_to_pnl     = tmo_flag_r;

endmodule

// File: tb/tb_io_dev_arbiter.sv
// Directed bench for io_dev_arbiter: a round-robin instance carries most tests, a
// fixed-priority instance shares the stimulus and is checked on the arbitration sequence.
module tb_io_dev_arbiter;

  logic clk;
  logic reset;

  logic [1:0] src_en;
  logic [1:0] snk_en;
  logic       clear_err;
  logic [9:0] src_data;
  logic       out_rdy;
  logic [4:0] out_data;
  logic [1:0] snk_ack;
  logic [1:0] src_rdy [2];
  logic       in_ack  [2];

  int n_cmp;
  int n_fail;

  io_dev_arbiter_if bus_rr ();
  io_dev_arbiter_if bus_fp ();

  assign bus_rr.src_en_from_pnl       = src_en;
  assign bus_rr.snk_en_from_pnl       = snk_en;
  assign bus_rr.clear_error_from_pnl  = clear_err;
  assign bus_rr.src_data_from_dev     = src_data;
  assign bus_rr.output_rdy_from_unit  = out_rdy;
  assign bus_rr.output_data_from_unit = out_data;
  assign bus_rr.snk_ack_from_dev      = snk_ack;
  assign bus_rr.src_rdy_from_dev      = src_rdy[0];
  assign bus_rr.input_ack_from_unit   = in_ack[0];

  assign bus_fp.src_en_from_pnl       = src_en;
  assign bus_fp.snk_en_from_pnl       = snk_en;
  assign bus_fp.clear_error_from_pnl  = clear_err;
  assign bus_fp.src_data_from_dev     = src_data;
  assign bus_fp.output_rdy_from_unit  = out_rdy;
  assign bus_fp.output_data_from_unit = out_data;
  assign bus_fp.snk_ack_from_dev      = snk_ack;
  assign bus_fp.src_rdy_from_dev      = src_rdy[1];
  assign bus_fp.input_ack_from_unit   = in_ack[1];

  io_dev_arbiter #(.RR_INPUT(1'b1), .TIMEOUT_CYCLES(16), .TMR_W(20)) u_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr.slave)
  );

  io_dev_arbiter #(.RR_INPUT(1'b0), .TIMEOUT_CYCLES(16), .TMR_W(20)) u_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish within 400000 time units");
    $fatal(1);
  end

  typedef struct packed {
    logic [1:0] en;
    logic [1:0] rdy;
    logic       ack;
    logic [9:0] data;
    logic       exp_rdy;
    logic [4:0] exp_data;
    logic [1:0] exp_sack;
    logic       exp_busy;
  } in_vec_t;

  in_vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic in_rdy_of(int k);
    return (k == 0) ? bus_rr.input_rdy_to_unit : bus_fp.input_rdy_to_unit;
  endfunction

  function automatic logic [4:0] in_data_of(int k);
    return (k == 0) ? bus_rr.input_data_to_unit : bus_fp.input_data_to_unit;
  endfunction

  function automatic logic [1:0] src_ack_of(int k);
    return (k == 0) ? bus_rr.src_ack_to_dev : bus_fp.src_ack_to_dev;
  endfunction

  function automatic logic in_busy_of(int k);
    return (k == 0) ? bus_rr.in_busy_to_pnl : bus_fp.in_busy_to_pnl;
  endfunction

  // One complete input character on instance k with both sources kept ready.
  task automatic xfer(input int k, input int c, input logic exp_src);
    logic       seen;
    logic       gi;
    logic [1:0] sack;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = in_rdy_of(k);
    end
    check($sformatf("arb%0d[%0d] unit_rdy_seen", k, c), seen, 1);
    check($sformatf("arb%0d[%0d] grant_data", k, c), in_data_of(k),
          exp_src ? 5'b10101 : 5'b01010);
    in_ack[k] = 1'b1;
    step();
    sack = src_ack_of(k);
    check($sformatf("arb%0d[%0d] src_ack", k, c), sack, exp_src ? 2'b10 : 2'b01);
    gi = sack[1];
    src_rdy[k][gi] = 1'b0;
    in_ack[k] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = !in_busy_of(k);
    end
    check($sformatf("arb%0d[%0d] back_to_idle", k, c), seen, 1);
    // reassert before the idle cycle samples, so both sources request together
    src_rdy[k][gi] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    src_en    = '0;
    snk_en    = '0;
    clear_err = 1'b0;
    src_data  = '0;
    out_rdy   = 1'b0;
    out_data  = '0;
    snk_ack   = '0;
    src_rdy[0] = '0;
    src_rdy[1] = '0;
    in_ack[0]  = 1'b0;
    in_ack[1]  = 1'b0;

    //            en     rdy    ack   data             rdy   data      sack   busy
    vecs[0]  = '{2'b01, 2'b11, 1'b0, 10'b01100_10011, 1'b0, 5'b10011, 2'b00, 1'b1};
    vecs[1]  = '{2'b01, 2'b11, 1'b0, 10'b01100_10011, 1'b1, 5'b10011, 2'b00, 1'b1};
    vecs[2]  = '{2'b10, 2'b11, 1'b0, 10'b11111_00001, 1'b1, 5'b10011, 2'b00, 1'b1};
    vecs[3]  = '{2'b10, 2'b11, 1'b1, 10'b11111_00001, 1'b0, 5'b10011, 2'b01, 1'b1};
    vecs[4]  = '{2'b10, 2'b11, 1'b1, 10'b11111_00001, 1'b0, 5'b10011, 2'b01, 1'b1};
    vecs[5]  = '{2'b10, 2'b11, 1'b0, 10'b11111_00001, 1'b0, 5'b10011, 2'b01, 1'b1};
    vecs[6]  = '{2'b10, 2'b10, 1'b0, 10'b01100_00001, 1'b0, 5'b10011, 2'b00, 1'b0};
    vecs[7]  = '{2'b10, 2'b10, 1'b0, 10'b01100_00001, 1'b0, 5'b01100, 2'b00, 1'b1};
    vecs[8]  = '{2'b00, 2'b10, 1'b0, 10'b01100_00001, 1'b1, 5'b01100, 2'b00, 1'b1};
    vecs[9]  = '{2'b00, 2'b10, 1'b1, 10'b01100_00001, 1'b0, 5'b01100, 2'b10, 1'b1};
    vecs[10] = '{2'b00, 2'b00, 1'b0, 10'b01100_00001, 1'b0, 5'b01100, 2'b00, 1'b0};
    vecs[11] = '{2'b11, 2'b00, 1'b0, 10'b01100_00001, 1'b0, 5'b01100, 2'b00, 1'b0};

    // reset state
    step();
    step();
    check("rst in_rdy",   bus_rr.input_rdy_to_unit, 0);
    check("rst in_data",  bus_rr.input_data_to_unit, 0);
    check("rst src_ack",  bus_rr.src_ack_to_dev, 0);
    check("rst out_ack",  bus_rr.output_ack_to_unit, 0);
    check("rst snk_rdy",  bus_rr.snk_rdy_to_dev, 0);
    check("rst snk_data", bus_rr.snk_data_to_dev, 0);
    check("rst busy",     {bus_rr.in_busy_to_pnl, bus_rr.out_busy_to_pnl}, 0);
    check("rst timeout",  bus_rr.timeout_to_pnl, 0);
    reset = 1'b0;

    // input handshake, enable masking, stable data, disable while granted
    for (int i = 0; i < 12; i++) begin
      src_en     = vecs[i].en;
      src_rdy[0] = vecs[i].rdy;
      in_ack[0]  = vecs[i].ack;
      src_data   = vecs[i].data;
      step();
      check($sformatf("vec[%0d] in_rdy", i),  bus_rr.input_rdy_to_unit,  vecs[i].exp_rdy);
      check($sformatf("vec[%0d] in_data", i), bus_rr.input_data_to_unit, vecs[i].exp_data);
      check($sformatf("vec[%0d] src_ack", i), bus_rr.src_ack_to_dev,     vecs[i].exp_sack);
      check($sformatf("vec[%0d] in_busy", i), bus_rr.in_busy_to_pnl,     vecs[i].exp_busy);
    end

    // arbitration order: round-robin alternates, fixed priority always picks src0
    src_rdy[0] = '0;
    do_reset();
    src_en   = 2'b11;
    src_data = {5'b10101, 5'b01010};
    src_rdy[0] = 2'b11;
    for (int c = 0; c < 4; c++) xfer(0, c, (c % 2) == 1);
    src_rdy[0] = 2'b00;
    src_rdy[1] = 2'b11;
    for (int c = 0; c < 4; c++) xfer(1, c, 1'b0);
    src_rdy[1] = 2'b00;
    src_en     = 2'b00;
    do_reset();

    // broadcast to both sinks, snk1 acks three cycles before snk0
    snk_en   = 2'b11;
    out_data = 5'b00110;
    out_rdy  = 1'b1;
    step();
    check("bc snk_rdy start", bus_rr.snk_rdy_to_dev, 2'b11);
    check("bc snk_data",      bus_rr.snk_data_to_dev, 5'b00110);
    check("bc out_busy",      bus_rr.out_busy_to_pnl, 1);
    step();
    snk_ack = 2'b10;
    step();
    check("bc snk_rdy after snk1", bus_rr.snk_rdy_to_dev, 2'b01);
    check("bc out_ack early",      bus_rr.output_ack_to_unit, 0);
    snk_ack = 2'b00;
    step();
    step();
    check("bc out_ack waiting", bus_rr.output_ack_to_unit, 0);
    snk_ack = 2'b01;
    step();
    check("bc out_ack",         bus_rr.output_ack_to_unit, 1);
    check("bc snk_rdy done",    bus_rr.snk_rdy_to_dev, 2'b00);
    out_rdy = 1'b0;
    step();
    check("bc hold while snk0 ack", bus_rr.output_ack_to_unit, 1);
    snk_ack = 2'b00;
    step();
    check("bc release ack",  bus_rr.output_ack_to_unit, 0);
    check("bc release busy", bus_rr.out_busy_to_pnl, 0);

    // no sink enabled: character discarded
    snk_en   = 2'b00;
    out_data = 5'b11011;
    out_rdy  = 1'b1;
    step();
    check("discard send snk_rdy", bus_rr.snk_rdy_to_dev, 2'b00);
    check("discard send ack",     bus_rr.output_ack_to_unit, 0);
    step();
    check("discard ack",          bus_rr.output_ack_to_unit, 1);
    check("discard snk_rdy",      bus_rr.snk_rdy_to_dev, 2'b00);
    out_rdy = 1'b0;
    step();
    check("discard release", bus_rr.output_ack_to_unit, 0);

    // watchdog on snk0, late ack ignored, sticky flag and clear
    snk_en   = 2'b01;
    out_data = 5'b01001;
    out_rdy  = 1'b1;
    step();
    check("tmo snk_rdy", bus_rr.snk_rdy_to_dev, 2'b01);
    repeat (15) step();
    check("tmo edge-1 flag", bus_rr.timeout_to_pnl, 2'b00);
    check("tmo edge-1 ack",  bus_rr.output_ack_to_unit, 0);
    check("tmo edge-1 rdy",  bus_rr.snk_rdy_to_dev, 2'b01);
    step();
    check("tmo flag",    bus_rr.timeout_to_pnl, 2'b01);
    check("tmo ack",     bus_rr.output_ack_to_unit, 1);
    check("tmo snk_rdy", bus_rr.snk_rdy_to_dev, 2'b00);
    out_rdy = 1'b0;
    snk_ack = 2'b01;
    step();
    check("tmo late ack ignored", bus_rr.output_ack_to_unit, 0);
    snk_ack = 2'b00;
    step();
    check("tmo sticky", bus_rr.timeout_to_pnl, 2'b01);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("tmo cleared", bus_rr.timeout_to_pnl, 2'b00);

    // partial timeout: snk1 answers, snk0 times out
    snk_en   = 2'b11;
    out_data = 5'b10001;
    out_rdy  = 1'b1;
    step();
    snk_ack = 2'b10;
    step();
    check("ptmo snk_rdy", bus_rr.snk_rdy_to_dev, 2'b01);
    snk_ack = 2'b00;
    repeat (14) step();
    check("ptmo edge-1 flag", bus_rr.timeout_to_pnl, 2'b00);
    step();
    check("ptmo flag", bus_rr.timeout_to_pnl, 2'b01);
    check("ptmo ack",  bus_rr.output_ack_to_unit, 1);
    out_rdy = 1'b0;
    step();
    check("ptmo release", bus_rr.output_ack_to_unit, 0);

    // reset in the middle of IN_FWD and OUT_SEND
    src_en     = 2'b01;
    src_data   = 10'b00000_11100;
    src_rdy[0] = 2'b01;
    snk_en     = 2'b01;
    out_data   = 5'b11100;
    out_rdy    = 1'b1;
    step();
    step();
    check("mid in_rdy",  bus_rr.input_rdy_to_unit, 1);
    check("mid snk_rdy", bus_rr.snk_rdy_to_dev, 2'b01);
    check("mid busy",    {bus_rr.in_busy_to_pnl, bus_rr.out_busy_to_pnl}, 2'b11);
    reset = 1'b1;
    step();
    check("mid rst in_rdy",  bus_rr.input_rdy_to_unit, 0);
    check("mid rst src_ack", bus_rr.src_ack_to_dev, 0);
    check("mid rst out_ack", bus_rr.output_ack_to_unit, 0);
    check("mid rst snk_rdy", bus_rr.snk_rdy_to_dev, 0);
    check("mid rst busy",    {bus_rr.in_busy_to_pnl, bus_rr.out_busy_to_pnl}, 0);
    check("mid rst timeout", bus_rr.timeout_to_pnl, 0);
    reset      = 1'b0;
    src_rdy[0] = '0;
    out_rdy    = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/io_dev_arbiter.md
Name: io_dev_arbiter

Overview:
- Sits between the I/O unit's 5-bit device handshake channels and the physical peripherals.
- Shares the single input channel between two input sources: photo tape reader (src0) and panel keyboard (src1).
- Broadcasts each output character to the enabled sinks: printer (snk0) and tape punch (snk1).
- Runs all handshakes 4-phase on both sides and adds a per-character sink watchdog.

Parameters:
- RR_INPUT, 1: 1 = round-robin between input sources; 0 = fixed priority, src0 wins.
- TIMEOUT_CYCLES, 20'd1000000: cycles a sink may leave a character un-acknowledged before it is force-completed.
- TMR_W, 20: width of the watchdog counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- src_en_from_pnl  in  2  level; bit i enables input source i
- snk_en_from_pnl  in  2  level; bit i enables output sink i
- clear_error_from_pnl  in  1  pulse; clears the timeout flags
- input_rdy_to_unit  out  1  handshake toward the I/O unit input side
- input_ack_from_unit  in  1  handshake from the I/O unit
- input_data_to_unit  out  5  character toward the I/O unit
- src_rdy_from_dev  in  2  per-source ready
- src_ack_to_dev  out  2  per-source ack
- src_data_from_dev  in  10  {src1[4:0], src0[4:0]}
- output_rdy_from_unit  in  1  handshake from the I/O unit output side
- output_ack_to_unit  out  1  handshake toward the I/O unit
- output_data_from_unit  in  5  character from the I/O unit
- snk_rdy_to_dev  out  2  per-sink ready
- snk_ack_from_dev  in  2  per-sink ack
- snk_data_to_dev  out  5  character toward the sinks
- in_busy_to_pnl  out  1  level; input FSM not in IN_IDLE
- out_busy_to_pnl  out  1  level; output FSM not in OUT_IDLE
- timeout_to_pnl  out  2  sticky per-sink timeout flag

Behaviour:

Reset:
- All outputs are 0. Both FSMs go to IDLE. Round-robin pointer = 0. Data registers = 0. Timer = 0.
- Reset mid-transaction abandons it immediately; all rdy/ack outputs are 0 the next cycle.

Input FSM (one-hot):
- IN_IDLE:
  - req = src_rdy_from_dev & src_en_from_pnl.
  - If req != 0, grant one source:
    - RR_INPUT = 1: the source differing from the last granted one wins when both request.
    - RR_INPUT = 0: src0 wins.
  - On grant: latch its data into data_in_r, record grant index, go IN_FWD.
- IN_FWD:
  - input_rdy_to_unit = 1; input_data_to_unit = data_in_r (stable).
  - When input_ack_from_unit = 1: go IN_DEVACK.
- IN_DEVACK:
  - input_rdy_to_unit = 0; src_ack_to_dev[grant] = 1.
  - When src_rdy_from_dev[grant] = 0 and input_ack_from_unit = 0: go IN_IDLE and update the RR pointer.
- Grant and data stay locked from IN_IDLE exit to IN_IDLE re-entry. Changes to src_en or to the other source's rdy are ignored mid-transfer.
- A source disabled while granted still completes its handshake.
- Latency: device rdy to unit rdy is 2 cycles (registered grant).

Output FSM (one-hot):
- OUT_IDLE:
  - When output_rdy_from_unit = 1: latch data into snk_data_to_dev, latch mask = snk_en_from_pnl, clear done = 00, clear timer, go OUT_SEND.
- OUT_SEND:
  - snk_rdy_to_dev[i] = mask[i] & ~done[i].
  - done[i] is set when snk_ack_from_dev[i] = 1, or on timeout.
  - Timeout: the timer increments every cycle in OUT_SEND. At TIMEOUT_CYCLES-1, every still-pending masked sink gets done[i] = 1 and timeout_to_pnl[i] = 1.
  - When done & mask == mask: go OUT_ACK.
  - mask = 00 (no sink enabled): character is discarded, next state is OUT_ACK directly.
- OUT_ACK:
  - output_ack_to_unit = 1.
  - When output_rdy_from_unit = 0 and (snk_ack_from_dev & mask & ~timed_out) == 0: go OUT_IDLE.
- A sink that timed out is ignored for the rest of this character. Its later ack is ignored in every state.
- timeout_to_pnl is cleared only by reset or clear_error_from_pnl. If a new timeout occurs in the same cycle as the clear, set wins.

Simultaneous events:
- The input and output FSMs are fully independent and may be active in the same cycle.
- Both sinks acking in the same cycle completes OUT_SEND in that cycle.

Test Plan:
1. src_en = 01, src0 presents 5'b10011 -> input_rdy_to_unit rises 2 cycles later with data 10011. Unit ack -> src_ack_to_dev = 01. Src0 rdy drops and unit ack drops -> IN_IDLE, in_busy = 0.
2. RR_INPUT = 1, both sources hold rdy continuously for 4 characters -> grants alternate 0,1,0,1. RR_INPUT = 0 -> grants 0,0,0,0.
3. snk_en = 11, unit outputs 5'b00110; snk1 acks 3 cycles before snk0 -> snk_rdy_to_dev[1] drops on snk1 ack; output_ack_to_unit rises only after snk0 ack.
4. snk_en = 00, unit rdy rises -> output_ack_to_unit = 1 one cycle after entering OUT_SEND; no snk_rdy asserted.
5. TIMEOUT_CYCLES = 16, snk_en = 01, snk0 never acks -> at cycle 16 of OUT_SEND timeout_to_pnl = 01 and output_ack_to_unit = 1. clear_error_from_pnl -> timeout_to_pnl = 00.
6. Assert reset in IN_FWD and in OUT_SEND -> next cycle all rdy/ack outputs 0, busy flags 0, timeout_to_pnl 00.
